// File: rtl/gray_ptr_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers:
// Gray conversions and side-select constants.
package gray_ptr_pkg;

  localparam int MAX_W = 32;

  localparam bit SIDE_WR = 1'b1;
  localparam bit SIDE_RD = 1'b0;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width,
// used to recover the remote binary pointer for the occupancy output.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray_ptr_pkg::gray2bin(32'(gray)));

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an asynchronous FIFO: registered binary/Gray pointer, remote
// pointer synchroniser and registered full/empty flag. Optional occupancy
// output level_o is built when GRAY_PTR_LEVEL_EN is defined.
module gray_ptr_ctrl
  import gray_ptr_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter bit IS_WRITE    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic [ADDR_W:0]   remote_gray_i,
  output logic [ADDR_W:0]   gray_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              accept_o,
  output logic              flag_o
`ifdef GRAY_PTR_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level_o
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_gray;
  logic [PW-1:0] full_cmp;
  logic          flag_next;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

  assign accept_o  = inc_i & ~flag_o;
  assign bin_next  = bin + PW'(accept_o);
  assign gray_next = PW'(bin2gray(32'(bin_next)));
  assign addr_o    = bin[ADDR_W-1:0];
  assign sync_gray = sync_q[SYNC_STAGES-1];

  // Remote pointer one lap ahead: top two Gray bits inverted, rest equal.
  assign full_cmp  = {~sync_gray[ADDR_W:ADDR_W-1], sync_gray[ADDR_W-2:0]};

  always_comb begin
    flag_next = 1'b0;
    if (IS_WRITE == SIDE_WR) begin
      flag_next = (gray_next == full_cmp);
    end else begin
      flag_next = (gray_next == sync_gray);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin    <= '0;
      gray_o <= '0;
      flag_o <= (IS_WRITE == SIDE_RD);
    end else begin
      bin    <= bin_next;
      gray_o <= gray_next;
      flag_o <= flag_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], remote_gray_i};
    end
  end

`ifdef GRAY_PTR_LEVEL_EN
  logic [PW-1:0] remote_bin;

  gray2bin #(.W(PW)) u_g2b (
    .gray (sync_gray),
    .bin  (remote_bin)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_o <= '0;
    end else if (IS_WRITE == SIDE_WR) begin
      level_o <= bin_next - remote_bin;
    end else begin
      level_o <= remote_bin - bin_next;
    end
  end
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl: a write-side and a read-side instance against an
// occupancy-based reference model, directed cases plus random traffic.
module tb_gray_ptr_ctrl;

  localparam int SYNC = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_w = 1'b0;
  logic       inc_r = 1'b0;
  logic       loop = 1'b0;
  logic [2:0] remote_w_drv = 3'b000;
  logic [2:0] remote_r_drv = 3'b000;
  logic [2:0] wr_remote, rd_remote;
  logic [2:0] wr_gray, rd_gray;
  logic [1:0] wr_addr, rd_addr;
  logic       wr_accept, rd_accept, wr_flag, rd_flag;
`ifdef GRAY_PTR_LEVEL_EN
  logic [2:0] wr_level, rd_level;
`endif

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int  m_bin   [2] = '{0, 0};
  bit  m_flag  [2] = '{1'b0, 1'b1};
  int  m_level [2] = '{0, 0};
  logic [2:0] hist_w [$];
  logic [2:0] hist_r [$];

  always #5 clk = ~clk;

  assign wr_remote = loop ? rd_gray : remote_w_drv;
  assign rd_remote = loop ? wr_gray : remote_r_drv;

  gray_ptr_ctrl #(.ADDR_W(2), .IS_WRITE(1'b1), .SYNC_STAGES(SYNC)) u_wr (
    .clk_i         (clk),
    .rst_i         (rst),
    .inc_i         (inc_w),
    .remote_gray_i (wr_remote),
    .gray_o        (wr_gray),
    .addr_o        (wr_addr),
    .accept_o      (wr_accept),
    .flag_o        (wr_flag)
`ifdef GRAY_PTR_LEVEL_EN
    ,
    .level_o       (wr_level)
`endif
  );

  gray_ptr_ctrl #(.ADDR_W(2), .IS_WRITE(1'b0), .SYNC_STAGES(SYNC)) u_rd (
    .clk_i         (clk),
    .rst_i         (rst),
    .inc_i         (inc_r),
    .remote_gray_i (rd_remote),
    .gray_o        (rd_gray),
    .addr_o        (rd_addr),
    .accept_o      (rd_accept),
    .flag_o        (rd_flag)
`ifdef GRAY_PTR_LEVEL_EN
    ,
    .level_o       (rd_level)
`endif
  );

  function automatic logic [2:0] toGray(input int b);
    int v;
    v = b & 7;
    return 3'(v ^ (v >> 1));
  endfunction

  function automatic int fromGray(input logic [2:0] g);
    for (int b = 0; b < 8; b++) begin
      if (toGray(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit iw, input bit ir,
                               input logic [2:0] rw, input logic [2:0] rr);
    rst = r;
    inc_w = iw;
    inc_r = ir;
    remote_w_drv = rw;
    remote_r_drv = rr;
    @(posedge clk);
    #2;
  endtask

  // Reference: occupancy = written - read (mod 8) against the remote pointer
  // as it was SYNC edges ago; full at DEPTH, empty at 0.
  always @(posedge clk) begin
    logic [2:0] rem [2];
    logic [2:0] sg [2];
    bit acc;
    int nb, rb, occ;
    rem[0] = loop ? toGray(m_bin[1]) : remote_w_drv;
    rem[1] = loop ? toGray(m_bin[0]) : remote_r_drv;
    if (rst) begin
      m_bin   = '{0, 0};
      m_flag  = '{1'b0, 1'b1};
      m_level = '{0, 0};
      hist_w = {};
      hist_r = {};
      repeat (SYNC) begin
        hist_w.push_back(3'b000);
        hist_r.push_back(3'b000);
      end
    end else begin
      sg[0] = hist_w[SYNC-1];
      sg[1] = hist_r[SYNC-1];
      for (int s = 0; s < 2; s++) begin
        acc = ((s == 0) ? inc_w : inc_r) && !m_flag[s];
        nb  = (m_bin[s] + (acc ? 1 : 0)) % 8;
        rb  = fromGray(sg[s]);
        occ = (s == 0) ? ((nb - rb) & 7) : ((rb - nb) & 7);
        m_flag[s]  = (s == 0) ? (occ == DEPTH) : (occ == 0);
        m_level[s] = occ;
        m_bin[s]   = nb;
      end
      hist_w.push_front(rem[0]);
      void'(hist_w.pop_back());
      hist_r.push_front(rem[1]);
      void'(hist_r.pop_back());
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("wr_gray",   wr_gray,   toGray(m_bin[0]));
      checkOutput("wr_addr",   wr_addr,   m_bin[0] % 4);
      checkOutput("wr_flag",   wr_flag,   m_flag[0]);
      checkOutput("wr_accept", wr_accept, inc_w & ~m_flag[0]);
      checkOutput("rd_gray",   rd_gray,   toGray(m_bin[1]));
      checkOutput("rd_addr",   rd_addr,   m_bin[1] % 4);
      checkOutput("rd_flag",   rd_flag,   m_flag[1]);
      checkOutput("rd_accept", rd_accept, inc_r & ~m_flag[1]);
`ifdef GRAY_PTR_LEVEL_EN
      checkOutput("wr_level",  wr_level,  m_level[0]);
      checkOutput("rd_level",  rd_level,  m_level[1]);
`endif
    end
  end

  initial begin
    logic [2:0] exp_g [4];
    bit iw, ir;
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110};

    // Reset held with requests pending
    applyStimulus(1, 1, 1, 3'b000, 3'b000);
    applyStimulus(1, 1, 1, 3'b000, 3'b000);
    checking = 1'b1;
    checkOutput("rst_wr_gray", wr_gray, 3'b000);
    checkOutput("rst_wr_addr", wr_addr, 2'd0);
    checkOutput("rst_wr_flag", wr_flag, 1'b0);
    checkOutput("rst_rd_gray", rd_gray, 3'b000);
    checkOutput("rst_rd_flag", rd_flag, 1'b1);

    // Write side fills from an empty remote
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 3'b000, 3'b000);
      checkOutput("fill_wr_gray", wr_gray, exp_g[i]);
    end
    checkOutput("fill_wr_flag", wr_flag, 1'b1);
    checkOutput("model_wr_bin", m_bin[0], 4);
    checkOutput("full_accept", wr_accept, 1'b0);
    applyStimulus(0, 1, 0, 3'b000, 3'b000);
    checkOutput("full_hold_gray", wr_gray, 3'b110);
    checkOutput("full_hold_addr", wr_addr, 2'd0);

    // Read side sees the remote advance after the synchroniser delay
    applyStimulus(1, 0, 0, 3'b000, 3'b000);
    applyStimulus(0, 0, 0, 3'b000, 3'b001);
    checkOutput("empty_k", rd_flag, 1'b1);
    applyStimulus(0, 0, 0, 3'b000, 3'b001);
    checkOutput("empty_k1", rd_flag, 1'b1);
    applyStimulus(0, 0, 0, 3'b000, 3'b001);
    checkOutput("empty_k2", rd_flag, 1'b0);
    checkOutput("model_rd_flag", m_flag[1], 1'b0);
    applyStimulus(0, 0, 1, 3'b000, 3'b001);
    checkOutput("pop_rd_gray", rd_gray, 3'b001);
    checkOutput("pop_rd_flag", rd_flag, 1'b1);

    // Reset in the middle of a burst
    applyStimulus(1, 0, 0, 3'b000, 3'b000);
    applyStimulus(0, 0, 0, 3'b011, 3'b000);
    applyStimulus(0, 0, 0, 3'b011, 3'b000);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 3'b011, 3'b000);
    checkOutput("burst_wr_gray", wr_gray, 3'b111);
    checkOutput("burst_wr_addr", wr_addr, 2'd1);
    applyStimulus(1, 1, 1, 3'b011, 3'b000);
    checkOutput("midrst_wr_gray", wr_gray, 3'b000);
    checkOutput("midrst_wr_addr", wr_addr, 2'd0);
    checkOutput("midrst_wr_flag", wr_flag, 1'b0);
    checkOutput("midrst_rd_flag", rd_flag, 1'b1);
    applyStimulus(0, 1, 0, 3'b011, 3'b000);
    checkOutput("after_rst_gray", wr_gray, 3'b001);

`ifdef GRAY_PTR_LEVEL_EN
    // Occupancy follows the remote pointer after synchronisation
    applyStimulus(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3'b000, 3'b000);
    checkOutput("level_3", wr_level, 3'd3);
    applyStimulus(0, 0, 0, 3'b011, 3'b000);
    applyStimulus(0, 0, 0, 3'b011, 3'b000);
    checkOutput("level_hold", wr_level, 3'd3);
    applyStimulus(0, 0, 0, 3'b011, 3'b000);
    checkOutput("level_1", wr_level, 3'd1);
`endif

    // Loopback: write and read sides wired to each other, alternating bias
    loop = 1'b1;
    applyStimulus(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 400; i++) begin
      if (((i / 50) % 2) == 0) begin
        iw = ($urandom_range(0, 9) < 8);
        ir = ($urandom_range(0, 9) < 3);
      end else begin
        iw = ($urandom_range(0, 9) < 3);
        ir = ($urandom_range(0, 9) < 8);
      end
      applyStimulus(0, iw, ir, 3'b000, 3'b000);
    end

    // Arbitrary remote pointers with occasional reset
    loop = 1'b0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom),
                    3'($urandom), 3'($urandom));
    end

    @(posedge clk);
    #2;
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_ptr_ctrl.md
# gray_ptr_ctrl

Parametrised FIFO pointer controller for one side of the asynchronous FIFO: holds a registered binary/Gray pointer pair, synchronises the opposite side's Gray pointer into its own clock, and produces a registered full (write side) or empty (read side) flag. Generalises plain binary-to-Gray conversion to a stateful pointer of configurable width and side, with overflow/underflow protection and optional occupancy output. One instance sits in each clock domain of the FIFO.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; FIFO depth is 2^ADDR_W; pointers are ADDR_W+1 bits; legal range ≥2
- IS_WRITE, 1, 1 = write side (flag is full), 0 = read side (flag is empty)
- SYNC_STAGES, 2, flops in remote-pointer synchroniser; legal range ≥2

Ports:
- clk_i  input  1  clock of this side
- rst_i  input  1  synchronous, active-high reset
- inc_i  input  1  push (write side) / pop (read side) request
- remote_gray_i  input  ADDR_W+1  opposite side's Gray pointer (other clock domain)
- gray_o  output  ADDR_W+1  local Gray pointer, registered, to opposite side
- addr_o  output  ADDR_W  RAM address = low ADDR_W bits of binary pointer
- accept_o  output  1  combinational: inc_i & ~flag_o
- flag_o  output  1  full (IS_WRITE=1) or empty (IS_WRITE=0), registered
- level_o  output  ADDR_W+1  occupancy as seen from this side (only with GRAY_PTR_LEVEL_EN)

## Operation
- Binary pointer bin (ADDR_W+1 bits); bin_next = bin + accept_o, modulo 2^(ADDR_W+1); gray_next = bin_next ^ (bin_next >> 1).
- bin and gray_o both register on the same edge; gray_o never derived combinationally from bin.
- Synchroniser: SYNC_STAGES flops on remote_gray_i; last stage = sync_gray. No logic between stages.
- Write side: flag_o <= (gray_next == {~sync_gray[ADDR_W:ADDR_W-1], sync_gray[ADDR_W-2:0]}).
- Read side: flag_o <= (gray_next == sync_gray).
- inc_i while flag_o=1: ignored; pointer, gray_o, addr_o hold; no error flag.
- Flags are pessimistic: full/empty may persist up to SYNC_STAGES+1 cycles after the opposite side frees/fills space; never optimistic.
- Reset (priority over inc_i): bin=0, gray_o=0, all sync flops=0, flag_o = 0 (write) / 1 (read), level_o=0. Reset mid-operation discards the pointer; both sides are reset together by system convention.

## Timing
- Accepted inc at edge N: addr_o, gray_o, flag_o reflect new pointer after edge N (latency 1).
- Write reaching full at edge N: flag_o=1 after N; a request in cycle N+1 is rejected.
- remote_gray_i change before edge K: visible in flag_o/level_o after edge K+SYNC_STAGES (SYNC_STAGES+1 edges incl. capture).
- Simultaneous local accept and remote change: flag uses gray_next and current sync_gray; consistent, still pessimistic.
- Pointer wrap 2^(ADDR_W+1)-1 → 0 is a single Gray-bit change; no special case.

## Configuration
- GRAY_PTR_LEVEL_EN defined: instantiate gray-to-binary of sync_gray; level_o <= bin_next − remote_bin (write) or remote_bin − bin_next (read), modulo 2^(ADDR_W+1), registered, reset 0.
- Undefined: no level_o port, no gray-to-binary logic; all other behaviour identical.

## Structure
- Shared package gray_ptr_pkg: bin2gray and gray2bin functions, SIDE_WR/SIDE_RD constants.
- One sub-module: gray2bin (parametrised width, combinational), used only under GRAY_PTR_LEVEL_EN.

## Test plan
(ADDR_W=2, SYNC_STAGES=2, pointers 3 bits)
- rst_i high 2 cycles with inc_i=1 -> gray_o=000, addr_o=0, flag_o=0 (write) / 1 (read), level_o=0.
- Write side, remote_gray_i=000, 4 back-to-back incs -> gray_o 001,011,010,110; flag_o=1 after 4th; 5th inc: accept_o=0, gray_o stays 110, addr_o=0.
- Read side, remote_gray_i 000→001 before edge K -> flag_o falls after edge K+2; one pop -> gray_o=001, flag_o=1 same edge.
- Write/read loopback, 8 accepted incs each -> bin wraps 111→000, gray_o 100→000, no spurious full/empty.
- Assert rst_i mid-burst at bin=101 -> next edge all outputs at reset values; first inc afterwards -> gray_o=001.
- GRAY_PTR_LEVEL_EN, write side, remote 000, 3 incs -> level_o=3; remote_gray_i=011 (bin 2) -> level_o=1 two edges after capture.
